wb_hb_mailbox: RTL and testbench
================================

Name: wb_hb_mailbox

Overview:
- Wishbone slave that sits directly downstream of the host-bus-to-Wishbone signal wrapper and consumes its strobe, write, address and write-data outputs.
- Host-bus accesses arrive asynchronous to clk and hold strobe high for the whole host cycle. This block synchronises them and executes exactly one register operation per access.
- Provides a TX FIFO (host to fabric), an RX FIFO (fabric to host), a status/control register and a scratch register.
- Returns read data on wb_rdData, which the wrapper drives back onto the host data bus.

Parameters:
- DATA_WIDTH, 16, width of Wishbone data, FIFO entries and registers.
- ADDR_WIDTH, 16, width of Wishbone address.
- FIFO_DEPTH, 16, entries per FIFO; must be a power of 2, range 4..256.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- wb_strobe  in  1  access strobe from the wrapper; asynchronous to clk.
- wb_cycle  in  1  cycle qualifier; ANDed with wb_strobe.
- wb_write  in  1  1 = write, 0 = read; sampled at access accept.
- wb_addr  in  ADDR_WIDTH  register address; sampled at access accept.
- wb_wrData  in  DATA_WIDTH  write data; sampled at access accept.
- wb_rdData  out  DATA_WIDTH  registered read data.
- tx_data  out  DATA_WIDTH  TX FIFO head word.
- tx_valid  out  1  TX FIFO not empty.
- tx_ready  in  1  fabric pops TX when tx_valid & tx_ready.
- rx_data  in  DATA_WIDTH  word pushed into the RX FIFO.
- rx_valid  in  1  fabric push request.
- rx_ready  out  1  RX FIFO not full.
- irq  out  1  level interrupt: RX FIFO not empty, or any sticky error bit set.

Behaviour:
- Reset: all registers, FIFO pointers, sticky bits, wb_rdData and the synchroniser are cleared to 0. tx_valid=0, rx_ready=1, irq=0.
- Synchroniser: s = wb_strobe & wb_cycle passes through 2 flops. An access is accepted on the first cycle the synchronised s is 1 after having been 0.
- Arm flag: after reset, or while s stays high across reset release, no access is accepted until s has been seen low once.
- Accept latency: 3 clk cycles after the s rising edge.
- Address, write flag and write data are sampled on the accept cycle. The host must hold them stable and keep the strobe high for at least 5 clk cycles.
- One accept per strobe pulse. A long strobe never causes repeated FIFO push or pop.
- Register map, decoded on wb_addr; any address >= 4 reads 0 and ignores writes:
  - addr 0, STATUS (read): bit0 tx_full, bit1 tx_empty, bit2 rx_full, bit3 rx_empty, bit4 tx_overflow (sticky), bit5 rx_underflow (sticky), bits 15:8 rx_count (saturating at 255), other bits 0.
  - addr 0, CTRL (write): bit0 clears the sticky bits, bit1 flushes TX, bit2 flushes RX. Bits are self-clearing pulses acting on the accept cycle.
  - addr 1, TX data: write pushes wb_wrData; read returns 0.
  - addr 2, RX data: read pops and returns the head word; write is ignored.
  - addr 3, SCRATCH: read/write, DATA_WIDTH bits.
- wb_rdData: loaded one cycle after the accept of a read and held until the next read accept. Write accepts leave it unchanged.
- TX write when full: data dropped, tx_overflow set.
- RX read when empty: wb_rdData=0, rx_underflow set, pointers unchanged.
- Simultaneous push and pop on the same FIFO are both honoured, including when full (pop frees a slot in the same cycle, count unchanged) and when empty (no bypass; the popper sees empty).
- A flush in the same cycle as a fabric push or pop: the flush wins and the FIFO becomes empty.
- Pointers are log2(FIFO_DEPTH)+1 bits wide; full/empty are decided by the wrap bit.
- Asserting reset mid-access aborts the access; no partial push or pop survives.

Decomposition:
- Package wb_hb_pkg holds the register addresses (ADDR_STATUS=0, ADDR_TX=1, ADDR_RX=2, ADDR_SCRATCH=3), the STATUS and CTRL bit indices, and the synchroniser depth (2).
- One sub-module, hb_sync_fifo: parameterised single-clock FIFO with push/pop, flush, full, empty and count. It is instantiated twice.

Test Plan:
- Reset release with strobe held high, then strobe low, then a write of 0xA5A5 to addr 3 -> no access before the low phase; a later read of addr 3 returns 0xA5A5.
- Write 1,2,3 to addr 1 with tx_ready=0; then tx_ready=1 -> tx_data presents 1,2,3 in order; STATUS bit1=1 afterwards.
- Push 17 words into TX with FIFO_DEPTH=16 -> word 17 dropped; STATUS bit4=1; CTRL write 0x0001 clears it to 0.
- Fabric pushes 0x1111 and 0x2222 into RX; host reads addr 2 twice with each strobe held 20 cycles -> returns 0x1111 then 0x2222 (exactly one pop per strobe); third read returns 0 with bit5=1; irq follows these states.
- TX full with tx_ready=1 and a host TX write accepted in the same cycle -> write accepted, count stays 16, no overflow flagged.
- CTRL write 0x0006 while rx_valid=1 -> both FIFOs empty the next cycle; STATUS reads 0x000A.

Source files
------------

// File: rtl/wb_hb_pkg.sv
// rtl/wb_hb_pkg.sv - register map, STATUS/CTRL bit positions and shared helpers for wb_hb_mailbox
package wb_hb_pkg;

  typedef enum logic [1:0] {
    ADDR_STATUS  = 2'd0,
    ADDR_TX      = 2'd1,
    ADDR_RX      = 2'd2,
    ADDR_SCRATCH = 2'd3
  } reg_addr_e;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_FULL  = 2;
  localparam int ST_RX_EMPTY = 3;
  localparam int ST_TX_OVF   = 4;
  localparam int ST_RX_UDF   = 5;
  localparam int ST_RX_CNT   = 8;

  localparam int CTRL_CLR_STICKY = 0;
  localparam int CTRL_FLUSH_TX   = 1;
  localparam int CTRL_FLUSH_RX   = 2;

  localparam int SYNC_STAGES = 2;

  // A 256-deep FIFO can hold 256 words, which does not fit the 8-bit field.
  function automatic logic [7:0] sat_count(input logic [8:0] c);
    return c[8] ? 8'hFF : c[7:0];
  endfunction

endpackage

// File: rtl/hb_sync_fifo.sv
// rtl/hb_sync_fifo.sv - single-clock FIFO with wrap-bit pointers, flush, and push/pop in the same cycle
module hb_sync_fifo #(
  parameter  int DW    = 16,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count    = wr_ptr - rd_ptr;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // No bypass when empty; a pop on a full FIFO frees the slot the push uses.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/wb_hb_mailbox.sv
// rtl/wb_hb_mailbox.sv - host-bus Wishbone mailbox: strobe synchroniser, register decode, TX/RX FIFOs
module wb_hb_mailbox
  import wb_hb_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_strobe,
  input  logic                  wb_cycle,
  input  logic                  wb_write,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_wrData,
  output logic [DATA_WIDTH-1:0] wb_rdData,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  irq
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] primed;
  logic                   s_sync;
  logic                   s_prev;
  logic                   armed;
  logic                   accept;

  logic sel_status, sel_tx, sel_rx, sel_scratch;
  logic is_wr, is_rd, ctrl_wr;
  logic tx_push, tx_pop, tx_flush, tx_drop;
  logic rx_pop, rx_flush, clr_sticky;

  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic [CW-1:0] tx_count, rx_count;
  logic [DATA_WIDTH-1:0] rx_head, status, rd_mux, scratch;
  logic tx_ovf, rx_udf;

  assign s_sync = sync_q[SYNC_STAGES-1];
  assign accept = s_sync && !s_prev && armed;

  // primed masks the reset value of the synchroniser so a strobe held across reset never arms.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      primed <= '0;
      s_prev <= 1'b0;
      armed  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], wb_strobe & wb_cycle};
      primed <= {primed[SYNC_STAGES-2:0], 1'b1};
      s_prev <= s_sync;
      if (primed[SYNC_STAGES-1] && !s_sync) armed <= 1'b1;
    end
  end

  assign sel_status  = (wb_addr == ADDR_WIDTH'(ADDR_STATUS));
  assign sel_tx      = (wb_addr == ADDR_WIDTH'(ADDR_TX));
  assign sel_rx      = (wb_addr == ADDR_WIDTH'(ADDR_RX));
  assign sel_scratch = (wb_addr == ADDR_WIDTH'(ADDR_SCRATCH));

  assign is_wr      = accept && wb_write;
  assign is_rd      = accept && !wb_write;
  assign ctrl_wr    = is_wr && sel_status;
  assign clr_sticky = ctrl_wr && wb_wrData[CTRL_CLR_STICKY];
  assign tx_flush   = ctrl_wr && wb_wrData[CTRL_FLUSH_TX];
  assign rx_flush   = ctrl_wr && wb_wrData[CTRL_FLUSH_RX];
  assign tx_push    = is_wr && sel_tx;
  assign rx_pop     = is_rd && sel_rx;
  assign tx_pop     = tx_valid && tx_ready;
  assign tx_drop    = tx_push && (tx_count == CW'(FIFO_DEPTH)) && !tx_pop;

  hb_sync_fifo #(.DW(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (tx_flush),
    .push      (tx_push),
    .push_data (wb_wrData),
    .pop       (tx_pop),
    .pop_data  (tx_data),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  hb_sync_fifo #(.DW(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (rx_flush),
    .push      (rx_valid),
    .push_data (rx_data),
    .pop       (rx_pop),
    .pop_data  (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  assign tx_valid = !tx_empty;
  assign rx_ready = !rx_full;
  assign irq      = !rx_empty || tx_ovf || rx_udf;

  always_comb begin
    status                  = '0;
    status[ST_TX_FULL]      = tx_full;
    status[ST_TX_EMPTY]     = tx_empty;
    status[ST_RX_FULL]      = rx_full;
    status[ST_RX_EMPTY]     = rx_empty;
    status[ST_TX_OVF]       = tx_ovf;
    status[ST_RX_UDF]       = rx_udf;
    status[ST_RX_CNT +: 8]  = sat_count(9'(rx_count));
  end

  always_comb begin
    rd_mux = '0;
    if (sel_status)       rd_mux = status;
    else if (sel_rx)      rd_mux = rx_empty ? '0 : rx_head;
    else if (sel_scratch) rd_mux = scratch;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_rdData <= '0;
      scratch   <= '0;
      tx_ovf    <= 1'b0;
      rx_udf    <= 1'b0;
    end else begin
      if (is_rd) wb_rdData <= rd_mux;
      if (is_wr && sel_scratch) scratch <= wb_wrData;
      if (clr_sticky) begin
        tx_ovf <= 1'b0;
        rx_udf <= 1'b0;
      end else begin
        if (tx_drop)             tx_ovf <= 1'b1;
        if (rx_pop && rx_empty)  rx_udf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_hb_mailbox.sv
// tb/tb_wb_hb_mailbox.sv - self-checking bench for wb_hb_mailbox against a queue-based mailbox model
module tb_wb_hb_mailbox;
  logic        clk = 1'b0;
  logic        rst;
  logic        wb_strobe, wb_cycle, wb_write;
  logic [15:0] wb_addr, wb_wrData, wb_rdData;
  logic [15:0] tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_ready, irq;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] tx_q[$];
  logic [15:0] rx_q[$];
  logic [15:0] scratch_m = 16'h0;
  logic [15:0] last_rd   = 16'h0;
  bit          ovf_m = 0;
  bit          udf_m = 0;

  wb_hb_mailbox dut (
    .clk(clk), .rst(rst), .wb_strobe(wb_strobe), .wb_cycle(wb_cycle),
    .wb_write(wb_write), .wb_addr(wb_addr), .wb_wrData(wb_wrData),
    .wb_rdData(wb_rdData), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] model_status();
    logic [15:0] s;
    s     = 16'h0;
    s[0]  = (tx_q.size() == 16);
    s[1]  = (tx_q.size() == 0);
    s[2]  = (rx_q.size() == 16);
    s[3]  = (rx_q.size() == 0);
    s[4]  = ovf_m;
    s[5]  = udf_m;
    s[15:8] = 8'((rx_q.size() > 255) ? 255 : rx_q.size());
    return s;
  endfunction

  function automatic bit model_irq();
    return (rx_q.size() != 0) || ovf_m || udf_m;
  endfunction

  function automatic logic [15:0] model_access(bit we, logic [15:0] a, logic [15:0] d);
    logic [15:0] r;
    r = last_rd;
    if (we) begin
      if (a == 16'd0) begin
        if (d[0]) begin ovf_m = 0; udf_m = 0; end
        if (d[1]) tx_q.delete();
        if (d[2]) rx_q.delete();
      end else if (a == 16'd1) begin
        if (tx_q.size() < 16) tx_q.push_back(d); else ovf_m = 1;
      end else if (a == 16'd3) begin
        scratch_m = d;
      end
    end else begin
      if (a == 16'd0)      r = model_status();
      else if (a == 16'd2) begin
        if (rx_q.size() == 0) begin r = 16'h0; udf_m = 1; end
        else r = rx_q.pop_front();
      end
      else if (a == 16'd3) r = scratch_m;
      else                 r = 16'h0;
      last_rd = r;
    end
    return r;
  endfunction

  task automatic host_begin(input bit we, input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    wb_write = we; wb_addr = a; wb_wrData = d;
    wb_strobe = 1'b1; wb_cycle = 1'b1;
  endtask

  task automatic host_end(output logic [15:0] rd);
    @(negedge clk);
    wb_strobe = 1'b0; wb_cycle = 1'b0;
    repeat (4) @(negedge clk);
    rd = wb_rdData;
  endtask

  task automatic host_access(input bit we, input logic [15:0] a, input logic [15:0] d,
                             input int hold, output logic [15:0] rd, output logic [15:0] exp);
    host_begin(we, a, d);
    repeat (hold) @(posedge clk);
    host_end(rd);
    exp = model_access(we, a, d);
  endtask

  task automatic fab_push(input logic [15:0] w);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = w;
    @(negedge clk);
    rx_valid = 1'b0;
    if (rx_q.size() < 16) rx_q.push_back(w);
  endtask

  task automatic fab_pop(output logic v, output logic [15:0] got);
    @(negedge clk);
    v = tx_valid; got = tx_data; tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] rd, exp;
    rst = 1'b0;
    wb_strobe = 1'b1; wb_cycle = 1'b1; wb_write = 1'b1; wb_addr = 16'd1; wb_wrData = 16'hDEAD;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); else n_pass++;
    n_checks++; if (rx_ready !== 1'b1) $display("FAIL reset_rx_ready: got %b expected 1", rx_ready); else n_pass++;
    n_checks++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b expected 0", irq); else n_pass++;
    n_checks++; if (wb_rdData !== 16'h0) $display("FAIL reset_rdData: got %h expected 0000", wb_rdData); else n_pass++;
    rst = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++; if (tx_valid !== 1'b0) $display("FAIL held_strobe_no_access: tx_valid got %b expected 0", tx_valid); else n_pass++;
    host_end(rd);
    host_access(1'b1, 16'd3, 16'hA5A5, 8, rd, exp);
    host_access(1'b0, 16'd3, 16'h0, 8, rd, exp);
    n_checks++; if (rd !== 16'hA5A5) $display("FAIL scratch_readback: got %h expected a5a5", rd); else n_pass++;
  endtask

  task automatic test_tx_order();
    logic [15:0] rd, exp;
    for (int i = 1; i <= 3; i++) host_access(1'b1, 16'd1, 16'(i), 8, rd, exp);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (tx_valid !== 1'b1 || tx_data !== 16'(i))
        $display("FAIL tx_order_%0d: valid=%b data=%h expected valid=1 data=%h", i, tx_valid, tx_data, 16'(i));
      else n_pass++;
      tx_ready = 1'b1;
      void'(tx_q.pop_front());
    end
    @(negedge clk);
    tx_ready = 1'b0;
    n_checks++; if (tx_valid !== 1'b0) $display("FAIL tx_drained: tx_valid got %b expected 0", tx_valid); else n_pass++;
    host_access(1'b0, 16'd0, 16'h0, 8, rd, exp);
    n_checks++; if (rd[1] !== 1'b1 || rd !== exp) $display("FAIL tx_empty_status: got %h expected %h", rd, exp); else n_pass++;
  endtask

  task automatic test_tx_overflow();
    logic [15:0] rd, exp;
    for (int i = 0; i < 17; i++) host_access(1'b1, 16'd1, 16'h100 + 16'(i), 6, rd, exp);
    host_access(1'b0, 16'd0, 16'h0, 8, rd, exp);
    n_checks++; if (rd !== 16'h0019) $display("FAIL tx_overflow_status: got %h expected 0019", rd); else n_pass++;
    n_checks++; if (irq !== 1'b1) $display("FAIL tx_overflow_irq: got %b expected 1", irq); else n_pass++;
    host_access(1'b1, 16'd0, 16'h0001, 8, rd, exp);
    host_access(1'b0, 16'd0, 16'h0, 8, rd, exp);
    n_checks++; if (rd !== 16'h0009) $display("FAIL ovf_cleared_status: got %h expected 0009", rd); else n_pass++;
    host_access(1'b1, 16'd0, 16'h0002, 8, rd, exp);
    host_access(1'b0, 16'd0, 16'h0, 8, rd, exp);
    n_checks++; if (rd !== 16'h000A) $display("FAIL tx_flush_status: got %h expected 000a", rd); else n_pass++;
  endtask

  task automatic test_rx_long_strobe();
    logic [15:0] rd, exp;
    fab_push(16'h1111);
    fab_push(16'h2222);
    n_checks++; if (irq !== 1'b1) $display("FAIL rx_irq_set: got %b expected 1", irq); else n_pass++;
    host_access(1'b0, 16'd0, 16'h0, 8, rd, exp);
    n_checks++; if (rd !== 16'h0202) $display("FAIL rx_count_status: got %h expected 0202", rd); else n_pass++;
    host_access(1'b0, 16'd2, 16'h0, 20, rd, exp);
    n_checks++; if (rd !== 16'h1111) $display("FAIL rx_read1: got %h expected 1111", rd); else n_pass++;
    host_access(1'b0, 16'd2, 16'h0, 20, rd, exp);
    n_checks++; if (rd !== 16'h2222) $display("FAIL rx_read2: got %h expected 2222", rd); else n_pass++;
    n_checks++; if (irq !== 1'b0) $display("FAIL rx_irq_clear: got %b expected 0", irq); else n_pass++;
    host_access(1'b0, 16'd2, 16'h0, 20, rd, exp);
    n_checks++; if (rd !== 16'h0000) $display("FAIL rx_underflow_data: got %h expected 0000", rd); else n_pass++;
    host_access(1'b0, 16'd0, 16'h0, 8, rd, exp);
    n_checks++; if (rd !== 16'h002A) $display("FAIL rx_underflow_status: got %h expected 002a", rd); else n_pass++;
    n_checks++; if (irq !== 1'b1) $display("FAIL rx_underflow_irq: got %b expected 1", irq); else n_pass++;
    host_access(1'b1, 16'd0, 16'h0001, 8, rd, exp);
  endtask

  task automatic test_full_simultaneous();
    logic [15:0] rd, exp, got;
    logic v;
    for (int i = 0; i < 16; i++) host_access(1'b1, 16'd1, 16'($urandom), 6, rd, exp);
    host_begin(1'b1, 16'd1, 16'hBEEF);
    @(posedge clk); @(posedge clk);
    @(negedge clk); tx_ready = 1'b1;
    @(posedge clk);
    @(negedge clk); tx_ready = 1'b0;
    repeat (6) @(posedge clk);
    host_end(rd);
    void'(tx_q.pop_front());
    tx_q.push_back(16'hBEEF);
    host_access(1'b0, 16'd0, 16'h0, 8, rd, exp);
    n_checks++; if (rd !== 16'h0009) $display("FAIL full_push_pop_status: got %h expected 0009", rd); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      fab_pop(v, got);
      exp = tx_q.pop_front();
      n_checks++;
      if (v !== 1'b1 || got !== exp) $display("FAIL full_drain_%0d: valid=%b data=%h expected %h", i, v, got, exp);
      else n_pass++;
    end
    n_checks++; if (exp !== 16'hBEEF) $display("FAIL full_last_word: got %h expected beef", exp); else n_pass++;
  endtask

  task automatic test_flush_with_push();
    logic [15:0] rd, exp;
    host_access(1'b1, 16'd1, 16'h0101, 6, rd, exp);
    host_access(1'b1, 16'd1, 16'h0202, 6, rd, exp);
    for (int i = 0; i < 3; i++) fab_push(16'h3000 + 16'(i));
    host_begin(1'b1, 16'd0, 16'h0006);
    rx_valid = 1'b1; rx_data = 16'h7777;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
    n_checks++; if (tx_valid !== 1'b0 || rx_ready !== 1'b1 || irq !== 1'b0)
      $display("FAIL flush_next_cycle: tx_valid=%b rx_ready=%b irq=%b expected 0 1 0", tx_valid, rx_ready, irq);
    else n_pass++;
    repeat (6) @(posedge clk);
    host_end(rd);
    exp = model_access(1'b1, 16'd0, 16'h0006);
    host_access(1'b0, 16'd0, 16'h0, 8, rd, exp);
    n_checks++; if (rd !== 16'h000A) $display("FAIL flush_status: got %h expected 000a", rd); else n_pass++;
  endtask

  task automatic test_random();
    logic [15:0] rd, exp, a, d, got;
    logic v;
    bit we;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 9))
        0, 1: fab_push(16'($urandom));
        2: begin
          fab_pop(v, got);
          n_checks++;
          if (tx_q.size() == 0) begin
            if (v !== 1'b0) $display("FAIL rand_pop_%0d: valid=%b expected 0", n, v); else n_pass++;
          end else begin
            exp = tx_q.pop_front();
            if (v !== 1'b1 || got !== exp) $display("FAIL rand_pop_%0d: valid=%b data=%h expected %h", n, v, got, exp);
            else n_pass++;
          end
        end
        default: begin
          a  = 16'($urandom_range(0, 5));
          we = 1'($urandom_range(0, 1));
          d  = (a == 16'd0) ? 16'($urandom_range(0, 7)) : 16'($urandom);
          host_access(we, a, d, $urandom_range(5, 10), rd, exp);
          n_checks++;
          if (rd !== exp) $display("FAIL rand_access_%0d: we=%b addr=%0d rdData=%h expected %h", n, we, a, rd, exp);
          else n_pass++;
        end
      endcase
      n_checks++;
      if (irq !== model_irq()) $display("FAIL rand_irq_%0d: got %b expected %b", n, irq, model_irq());
      else n_pass++;
    end
  endtask

  initial begin
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 16'h0;
    test_reset();
    test_tx_order();
    test_tx_overflow();
    test_rx_long_strobe();
    test_full_simultaneous();
    test_flush_with_push();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
